// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one (SIZE+1)-bit slice reused over WORDS cycles.
// Optional signed-overflow flag is built when OVERFLOW_DETECT_EN is defined.

module RippleCarryAddSub #(
  parameter int SIZE = 15
) (
  input  logic [SIZE:0] a,
  input  logic [SIZE:0] b,
  input  logic          c_in,
  output logic [SIZE:0] s,
  output logic          c_out
);

  logic [SIZE:0] bx;
  logic          cy;

  // The slice inverts b whenever c_in is set; callers must pre-compensate.
  always_comb begin
    bx = b ^ {(SIZE+1){c_in}};
    s  = '0;
    cy = c_in;
    for (int i = 0; i <= SIZE; i++) begin
      s[i] = a[i] ^ bx[i] ^ cy;
      cy   = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
    c_out = cy;
  end

endmodule

module addsub_seq_ctrl #(
  parameter int SIZE  = 15,
  parameter int WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sub,
  input  logic [WORDS*(SIZE+1)-1:0]   a,
  input  logic [WORDS*(SIZE+1)-1:0]   b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORDS*(SIZE+1)-1:0]   s,
  output logic                        c_out,
  output logic                        ovf
);

  localparam int SW    = SIZE + 1;
  localparam int W     = WORDS * SW;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             accept, step, last;
  logic [W-1:0]     a_reg, b_reg;
  logic             sub_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [SW-1:0]    a_slice, b_slice, slice_b, slice_s;
  logic             slice_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = (idx == LAST);
    case (state)
      IDLE: if (in_valid) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c_out     = carry;

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_slice = a_reg[k*SW +: SW];
        b_slice = b_reg[k*SW +: SW];
      end
    end
  end

  // Pre-invert by carry so the slice's own inversion nets out to b XOR sub.
  assign slice_b = b_slice ^ {SW{sub_reg ^ carry}};

  RippleCarryAddSub #(.SIZE(SIZE)) u_slice (
    .a     (a_slice),
    .b     (slice_b),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
      s       <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      sub_reg <= sub;
      idx     <= '0;
      carry   <= sub;
    end else if (step) begin
      carry <= slice_cout;
      for (int k = 0; k < WORDS; k++) begin
        if (idx == IDX_W'(k)) s[k*SW +: SW] <= slice_s;
      end
      if (!last) idx <= idx + 1'b1;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf_reg;

  // Overflow when operands agree in sign but the result's sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (accept)
      ovf_reg <= 1'b0;
    else if (step && last)
      ovf_reg <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (slice_s[SIZE] != a_reg[W-1]);
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed self-checking bench for addsub_seq_ctrl (SIZE=15, WORDS=4, 64-bit operands).

module tb_addsub_seq_ctrl;

  localparam int SIZE  = 15;
  localparam int WORDS = 4;
  localparam int W     = 64;
`ifdef OVERFLOW_DETECT_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, c_out, ovf;
  logic [W-1:0] s;

  int checks = 0;
  int errors = 0;

  addsub_seq_ctrl #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic op, input logic [63:0] x, input logic [63:0] y);
    in_valid = 1'b1;
    sub      = op;
    a        = x;
    b        = y;
    tick;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge to out_valid; optionally scrambles inputs meanwhile.
  task automatic wait_result(input string tag, input bit scramble);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      if (scramble) begin
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = ~sub;
      end
      tick;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd4);
  endtask

  task automatic check_output(input string tag, input logic [63:0] exp_s, input logic exp_c,
                              input logic exp_o);
    check({tag, " s"}, s, exp_s);
    check({tag, " c_out"}, 64'(c_out), 64'(exp_c));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_o));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, " in_ready after ack"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid after ack"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset s", s, 64'd0);
    check("reset c_out", 64'(c_out), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    #10 rst_n = 1'b1;
    tick;

    apply_stimulus(1'b0, 64'h00000000_FFFFFFFF, 64'h1);
    wait_result("add boundary", 1'b0);
    check_output("add boundary", 64'h00000001_00000000, 1'b0, 1'b0);

    apply_stimulus(1'b1, 64'd5, 64'd3);
    wait_result("sub no borrow", 1'b0);
    check_output("sub no borrow", 64'h2, 1'b1, 1'b0);

    apply_stimulus(1'b1, 64'd0, 64'd1);
    wait_result("sub borrow", 1'b0);
    check_output("sub borrow", 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);

    apply_stimulus(1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1);
    wait_result("add ovf", 1'b0);
    check_output("add ovf", 64'h80000000_00000000, 1'b0, OVF_ON);

    apply_stimulus(1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1);
    wait_result("add wrap", 1'b0);
    check_output("add wrap", 64'h0, 1'b1, 1'b0);

    apply_stimulus(1'b1, 64'h80000000_00000000, 64'h1);
    wait_result("sub ovf", 1'b0);
    check_output("sub ovf", 64'h7FFFFFFF_FFFFFFFF, 1'b1, OVF_ON);

    // Backpressure: hold the result while a new request waits.
    apply_stimulus(1'b0, 64'd10, 64'd20);
    wait_result("backpressure", 1'b0);
    in_valid = 1'b1;
    a        = 64'd100;
    b        = 64'd1;
    sub      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold s", s, 64'd30);
      check("hold c_out", 64'(c_out), 64'd0);
      check("hold in_ready", 64'(in_ready), 64'd0);
      check("hold out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("release in_ready", 64'(in_ready), 64'd1);
    check("release out_valid", 64'(out_valid), 64'd0);
    tick;
    in_valid = 1'b0;
    wait_result("pending", 1'b0);
    check_output("pending", 64'd101, 1'b0, 1'b0);

    apply_stimulus(1'b1, 64'h01234567_89ABCDEF, 64'h11111111_11111111);
    wait_result("hold-off", 1'b1);
    check_output("hold-off", 64'hF0123456_789ABCDE, 1'b0, 1'b0);

    // Abort with reset once two slices have been written.
    apply_stimulus(1'b0, 64'h11112222_33334444, 64'h1);
    tick;
    tick;
    check("partial s", {32'h0, s[31:0]}, 64'h33334445);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort s", s, 64'd0);
    check("abort c_out", 64'(c_out), 64'd0);
    #4 rst_n = 1'b1;
    tick;
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    apply_stimulus(1'b0, 64'hFFFF, 64'h1);
    wait_result("post-reset", 1'b0);
    check_output("post-reset", 64'h10000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It reuses one (SIZE+1)-bit RippleCarryAddSub slice over WORDS cycles to add or subtract operands of WORDS*(SIZE+1) bits. The slice's carry is held in a register between cycles. It has a valid/ready handshake on both the operand side and the result side, and sits between the register-file/ALU front end and the shared adder datapath.

Parameters:
SIZE, 15, MSB index of one adder slice; slice width is SIZE+1.
WORDS, 4, number of slices per operation; operand width W = WORDS*(SIZE+1). Legal values are 2 to 16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept an operation.
sub  input  1  0 = a+b, 1 = a-b.
a  input  W  operand A (unsigned or two's complement).
b  input  W  operand B.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
s  output  W  result, registered.
c_out  output  1  carry out of bit W-1; for sub, 1 = no borrow.
ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, c_out=0, ovf=0, idx=0, carry register=0.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready, the block captures a, b and sub into internal registers, sets idx=0, sets carry=sub, and goes to RUN. In_ready is 1 only in IDLE.
  - RUN: one slice is computed per cycle, slice k = bits [k*(SIZE+1) +: SIZE+1]. The slice result is written to s slice idx and carry<=slice c_out. If idx==WORDS-1, go to DONE; otherwise idx<=idx+1.
  - DONE: out_valid=1, with s, c_out and ovf stable. When out_ready=1, go to IDLE; out_valid drops the next cycle. With out_ready=0, everything holds indefinitely.
- Latency: out_valid rises exactly WORDS cycles after the accept edge. Back-to-back throughput is one operation per WORDS+2 cycles.
- Adder drive rule: the slice inverts b when c_in=1, so the controller compensates:
  - slice c_in = carry register;
  - slice b = b_slice XOR {SIZE+1{sub XOR carry}}.
  - Net effect: the slice sees b_slice XOR sub with true carry-in. This is required for correct borrow chaining.
- c_out is the carry register after the last slice.
- s slices not yet computed hold their previous values. Consumers must use s only while out_valid=1.
- Inputs a, b and sub are ignored outside the IDLE accept cycle. Changing them mid-operation has no effect.
- in_valid in RUN or DONE is not accepted. The requester must hold it until in_ready.
- rst_n asserted mid-RUN or mid-DONE aborts immediately to reset values. The result is lost and no out_valid is produced.
- No internal queueing: at most one operation is in flight.

Optional Feature:
OVERFLOW_DETECT_EN:
- Defined: ovf is registered on the final RUN cycle as (a[W-1] == beff[W-1]) && (s_final[W-1] != a[W-1]), where beff = b XOR {W{sub}}. It is valid with out_valid and reset to 0.
- Undefined: ovf is tied to 0 and no overflow logic is built. All other behaviour is identical.

Test Plan:
All cases use WORDS=4, SIZE=15 (W=64).
1. Add across a slice boundary: sub=0, a=0x00000000_FFFFFFFF, b=0x1 -> s=0x00000001_00000000, c_out=0, ovf=0, out_valid 4 cycles after accept.
2. Subtract with no borrow: sub=1, a=5, b=3 -> s=0x2, c_out=1. Subtract with borrow: sub=1, a=0, b=1 -> s=0xFFFFFFFF_FFFFFFFF, c_out=0.
3. Signed overflow (macro defined): sub=0, a=0x7FFFFFFF_FFFFFFFF, b=1 -> s=0x80000000_00000000, c_out=0, ovf=1. Same case with macro undefined -> ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> s/c_out stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> return to IDLE, then the pending request is accepted.
5. Reset mid-operation: assert rst_n=0 at idx=2 -> out_valid=0, in_ready=1 immediately, s=0. The next operation (sub=0, a=0xFFFF, b=1) -> s=0x10000.
6. Input hold-off: change a/b/sub every cycle during RUN -> result matches the operands captured at accept.
